oper_b_pipe: RTL
================

OPER_B_PIPE -- requirements
Module: oper_b_pipe

Parameters
REQ-001 SHALL provide WIDTH, default 32, operand and output data width in bits.
REQ-002 SHALL provide IMM_W, default 16, raw immediate width in bits; legal range 1..WIDTH.
REQ-003 SHALL provide NUM_FWD, default 2, number of forwarding channels; legal range 1..8.
REQ-004 SHALL derive SEL_W = clog2(NUM_FWD+2) as the select width; no separate port parameter.

Interface
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat this cycle.
REQ-009 dat_b  input  WIDTH  register-file operand B.
REQ-010 immediate  input  IMM_W  raw immediate field.
REQ-011 imm_signed  input  1  1 = sign-extend immediate, 0 = zero-extend.
REQ-012 sel_oper_b  input  SEL_W  source select: 0 = dat_b, 1 = extended immediate, 2+k = forwarding channel k.
REQ-013 fwd_data  input  NUM_FWD*WIDTH  forwarding channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-014 out_valid  output  1  output_b holds a valid beat.
REQ-015 out_ready  input  1  downstream accepts the beat.
REQ-016 output_b  output  WIDTH  selected operand B.
REQ-017 sel_error  output  1  qualifies output_b: select was out of range.

Function
REQ-018 Input handshake: beat accepted when in_valid && in_ready on a rising edge; output handshake: beat retired when out_valid && out_ready.
REQ-019 Selection and extension SHALL be evaluated combinationally on the input beat and captured at acceptance; inputs are don't-care when not accepted.
REQ-020 Immediate extension: bits [IMM_W-1:0] = immediate; bits above = immediate[IMM_W-1] if imm_signed else 0; IMM_W = WIDTH means no extension.
REQ-021 sel_oper_b >= NUM_FWD+2: captured data = 0, captured sel_error = 1; otherwise sel_error = 0.
REQ-022 Storage: one output register (OUT) plus one skid register (SKID), each holding {data, sel_error, valid}.
REQ-023 in_ready = !SKID.valid, driven from registered state only (no combinational path from out_ready); forced 0 while rst high.
REQ-024 Accepted beat goes to OUT if OUT empty or OUT retires same cycle and SKID empty; else to SKID.
REQ-025 OUT retiring with SKID valid: SKID moves to OUT, SKID empties; simultaneous acceptance impossible (in_ready = 0).
REQ-026 Latency: accepted beat visible on output_b/out_valid the cycle after acceptance when not stalled; sustained throughput 1 beat/cycle with out_ready high.
REQ-027 Beats SHALL retire in acceptance order; none dropped or duplicated.
REQ-028 output_b and sel_error SHALL hold stable while out_valid && !out_ready.
REQ-029 OUT empty: output_b and sel_error SHALL retain last values (no new-data leakage); out_valid = 0.

Reset
REQ-030 rst assertion SHALL immediately clear OUT.valid and SKID.valid, zero output_b and sel_error, drop in_ready to 0, independent of clk.
REQ-031 In-flight beats at reset are discarded; first cycle after deassertion in_ready = 1, out_valid = 0.

Verification
REQ-032 WIDTH=32, IMM_W=16: immediate=0x8001, sel=1, imm_signed=1 -> output_b=0xFFFF8001 next cycle; imm_signed=0 -> 0x00008001.
REQ-033 NUM_FWD=2: fwd_data={0xBBBB0002,0xAAAA0001}, sel=3 -> output_b=0xBBBB0002; sel=0, dat_b=0x12345678 -> 0x12345678; sel_error=0 throughout.
REQ-034 NUM_FWD=1: sel=3 -> output_b=0x00000000, sel_error=1, out_valid=1.
REQ-035 out_ready=0, push A=0x11 then B=0x22 back-to-back -> in_ready=0 after B, output_b=0x11 held; out_ready=1 -> 0x11 retires, then 0x22 next cycle, in_ready=1 again.
REQ-036 Continuous in_valid/out_ready=1 for 8 beats 0x1..0x8 -> outputs 0x1..0x8 on 8 consecutive cycles, one cycle after each acceptance.
REQ-037 OUT and SKID both full, assert rst mid-cycle -> out_valid=0, output_b=0 immediately; after release in_ready=1, no stale beat emerges.

Source files
------------

// File: rtl/oper_b_pipe.sv
`default_nettype none
// ============================================================================
// Module   : oper_b_pipe
// Purpose  : Operand-B source select stage. Picks operand B from the
//            register file, an extended immediate or one of NUM_FWD
//            forwarding channels, then buffers it in a two-entry
//            (output + skid) valid/ready pipeline register.
// Ports    : clk, rst                 - clock, async active-high reset
//            in_valid / in_ready      - upstream handshake
//            dat_b, immediate,
//            imm_signed, sel_oper_b,
//            fwd_data                 - operand sources and select
//            out_valid / out_ready    - downstream handshake
//            output_b, sel_error      - selected operand, bad-select flag
// Revision : 1.0 - initial release
// ============================================================================
module oper_b_pipe #(
  parameter int WIDTH   = 32,
  parameter int IMM_W   = 16,
  parameter int NUM_FWD = 2,
  localparam int SEL_W  = $clog2(NUM_FWD + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         dat_b,
  input  logic [IMM_W-1:0]         immediate,
  input  logic                     imm_signed,
  input  logic [SEL_W-1:0]         sel_oper_b,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         output_b,
  output logic                     sel_error
);

  // --------------------------------------------------------------------------
  // Source selection (combinational, captured on acceptance)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] imm_fill;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  // The fill pattern is shifted above the raw field; when IMM_W equals WIDTH
  // the shift pushes every fill bit out and no extension takes place.
  assign imm_fill = (imm_signed && immediate[IMM_W-1]) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign ext_imm  = (imm_fill << IMM_W) | WIDTH'(immediate);

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    if (sel_oper_b == SEL_W'(0)) begin
      sel_data = dat_b;
      sel_err  = 1'b0;
    end else if (sel_oper_b == SEL_W'(1)) begin
      sel_data = ext_imm;
      sel_err  = 1'b0;
    end else begin
      for (int k = 0; k < NUM_FWD; k++) begin
        if (sel_oper_b == SEL_W'(k + 2)) begin
          sel_data = fwd_data[k*WIDTH +: WIDTH];
          sel_err  = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output + skid registers
  // --------------------------------------------------------------------------
  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_err_q,    out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             skid_err_q,   skid_err_d;

  logic accept;
  logic retire;

  // Ready depends only on the skid flag, so out_ready never reaches in_ready.
  assign accept = in_valid && !skid_valid_q;
  assign retire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;

    if (!out_valid_q || retire) begin
      if (skid_valid_q) begin
        // Skid drains into OUT; accept is blocked because in_ready is low.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        // Data is only overwritten by a new beat, so an empty OUT keeps
        // showing the last retired value.
        if (accept) begin
          out_data_d = sel_data;
          out_err_d  = sel_err;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = sel_data;
      skid_err_d   = sel_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
    end
  end

  // Gating with rst keeps the stage closed for the whole reset pulse even
  // though the cleared skid flag alone would already read as ready.
  assign in_ready  = !skid_valid_q && !rst;
  assign out_valid = out_valid_q;
  assign output_b  = out_data_q;
  assign sel_error = out_err_q;

endmodule
`default_nettype wire
